// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - memory handshake and datapath control bundle for the RV32I multicycle sequencer
interface multicycle_control_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_MemRdata;
  logic                  i_MemReady;
  logic                  i_Zero;
  logic [DATA_WIDTH-1:0] o_Instruction;
  logic                  o_MemRead;
  logic                  o_MemWrite;
  logic                  o_IorD;
  logic                  o_PCWrite;
  logic                  o_OldPCWrite;
  logic                  o_RegWrite;
  logic                  o_MemToReg;
  logic [1:0]            o_ALUSrcA;
  logic [1:0]            o_ALUSrcB;
  logic [1:0]            o_ALUOp;
  logic                  o_Illegal;
  logic [3:0]            o_State;

  modport master (
    input  i_MemRdata, i_MemReady, i_Zero,
    output o_Instruction, o_MemRead, o_MemWrite, o_IorD, o_PCWrite, o_OldPCWrite,
           o_RegWrite, o_MemToReg, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_Illegal, o_State
  );

  modport slave (
    output i_MemRdata, i_MemReady, i_Zero,
    input  o_Instruction, o_MemRead, o_MemWrite, o_IorD, o_PCWrite, o_OldPCWrite,
           o_RegWrite, o_MemToReg, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_Illegal, o_State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multicycle sequencer: fetch, decode, execute, memory, writeback, trap
module multicycle_control_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  multicycle_control_unit_if.master bus
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_OLDPC = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO  = 2'd2;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;
  localparam logic [1:0] ALU_ADD     = 2'd0;
  localparam logic [1:0] ALU_SUB     = 2'd1;
  localparam logic [1:0] ALU_FUNCT   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_LUI      = 4'd4,
    S_AUIPC    = 4'd5,
    S_WB_ALU   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] instr;
  logic [CW-1:0]         wait_cnt;
  logic [1:0]            src_a_q;
  logic [1:0]            src_b_q;
  logic [1:0]            alu_op_q;

  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       pc_write;
  logic       old_pc_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] alu_op;
  logic       cnt_inc;
  logic       ir_load;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       timed_out;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign timed_out = (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Select history lets writeback and memory-access states replay the previous cycle's ALU routing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      instr    <= '0;
      wait_cnt <= '0;
      src_a_q  <= 2'd0;
      src_b_q  <= 2'd0;
      alu_op_q <= 2'd0;
    end else begin
      if (ir_load) begin
        instr <= bus.i_MemRdata;
      end
      wait_cnt <= cnt_inc ? wait_cnt + 1'b1 : '0;
      src_a_q  <= src_a;
      src_b_q  <= src_b;
      alu_op_q <= alu_op;
    end
  end

  always_comb begin
    next_state   = state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    pc_write     = 1'b0;
    old_pc_write = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    src_a        = SRC_A_OLDPC;
    src_b        = SRC_B_RS2;
    alu_op       = ALU_ADD;
    cnt_inc      = 1'b0;
    ir_load      = 1'b0;

    unique case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = SRC_B_FOUR;
        if (bus.i_MemReady) begin
          ir_load      = 1'b1;
          pc_write     = 1'b1;
          old_pc_write = 1'b1;
          next_state   = S_DECODE;
        end else if (timed_out) begin
          next_state = S_TRAP;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_DECODE: begin
        unique case (opcode)
          OP_R:               next_state = S_EXEC_R;
          OP_I:               next_state = S_EXEC_I;
          OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
          OP_BRANCH:          next_state = S_BRANCH;
          OP_LUI:             next_state = S_LUI;
          OP_AUIPC:           next_state = S_AUIPC;
          default:            next_state = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_RS2;
        alu_op     = ALU_FUNCT;
        next_state = S_WB_ALU;
      end

      S_EXEC_I: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_IMM;
        alu_op     = ALU_FUNCT;
        next_state = S_WB_ALU;
      end

      S_LUI: begin
        src_a      = SRC_A_ZERO;
        src_b      = SRC_B_IMM;
        alu_op     = ALU_ADD;
        next_state = S_WB_ALU;
      end

      S_AUIPC: begin
        src_a      = SRC_A_OLDPC;
        src_b      = SRC_B_IMM;
        alu_op     = ALU_ADD;
        next_state = S_WB_ALU;
      end

      S_WB_ALU: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        src_a      = src_a_q;
        src_b      = src_b_q;
        alu_op     = alu_op_q;
        next_state = S_FETCH;
      end

      S_MEM_ADDR: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_IMM;
        alu_op     = ALU_ADD;
        next_state = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD, S_MEM_WR: begin
        mem_read  = (state == S_MEM_RD);
        mem_write = (state == S_MEM_WR);
        iord      = 1'b1;
        src_a     = src_a_q;
        src_b     = src_b_q;
        alu_op    = alu_op_q;
        if (bus.i_MemReady) begin
          next_state = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (timed_out) begin
          next_state = S_TRAP;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_RS2;
        alu_op = ALU_SUB;
        unique case (funct3)
          3'b000:  pc_write = bus.i_Zero;
          3'b001:  pc_write = ~bus.i_Zero;
          default: pc_write = 1'b0;
        endcase
        next_state = S_FETCH;
      end

      S_TRAP: begin
        next_state = S_TRAP;
      end

      default: begin
        next_state = S_TRAP;
      end
    endcase
  end

  // Reset masks every request combinationally so an access in flight is dropped at once.
  assign bus.o_Instruction = instr;
  assign bus.o_MemRead     = mem_read     & ~i_rst;
  assign bus.o_MemWrite    = mem_write    & ~i_rst;
  assign bus.o_IorD        = iord         & ~i_rst;
  assign bus.o_PCWrite     = pc_write     & ~i_rst;
  assign bus.o_OldPCWrite  = old_pc_write & ~i_rst;
  assign bus.o_RegWrite    = reg_write    & ~i_rst;
  assign bus.o_MemToReg    = mem_to_reg   & ~i_rst;
  assign bus.o_ALUSrcA     = i_rst ? 2'd0 : src_a;
  assign bus.o_ALUSrcB     = i_rst ? 2'd0 : src_b;
  assign bus.o_ALUOp       = i_rst ? 2'd0 : alu_op;
  assign bus.o_Illegal     = (state == S_TRAP);
  assign bus.o_State       = state;

endmodule
